saturating_accumulator: RTL and testbench

SATURATING_ACCUMULATOR -- requirements
Module: saturating_accumulator

---
 rtl/saturating_accumulator_pkg.sv | 19 +
 rtl/saturating_accumulator_sat_clamp.sv | 38 +++
 rtl/saturating_accumulator.sv | 107 ++++++++++
 tb/tb_saturating_accumulator.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/saturating_accumulator_pkg.sv
// Shared types and clamp-limit helpers for the
// saturating accumulator and future saturating blocks.
package saturating_accumulator_pkg;

  typedef enum logic {
    MODE_PASS = 1'b0,
    MODE_ACC  = 1'b1
  } mode_e;

  function automatic longint sat_max(input int w, input bit s);
    return s ? (longint'(1) <<< (w - 1)) - 1
             : (longint'(1) <<< w) - 1;
  endfunction

  function automatic longint sat_min(input int w, input bit s);
    return s ? -(longint'(1) <<< (w - 1)) : longint'(0);
  endfunction

endpackage

// File: rtl/saturating_accumulator_sat_clamp.sv
// Combinational clamp of a wide raw value into OUT_WIDTH
// with a flag telling whether the value was limited.
module sat_clamp
  import saturating_accumulator_pkg::*;
#(
  parameter int RAW_WIDTH = 10,
  parameter int OUT_WIDTH = 4,
  parameter int SIGNED    = 0
) (
  input  logic [RAW_WIDTH-1:0] raw_i,
  output logic [OUT_WIDTH-1:0] res_o,
  output logic                 sat_o
);

  localparam bit SG = (SIGNED != 0);
  localparam logic [RAW_WIDTH-1:0] MAXV =
    RAW_WIDTH'(sat_max(OUT_WIDTH, SG));
  localparam logic [RAW_WIDTH-1:0] MINV =
    RAW_WIDTH'(sat_min(OUT_WIDTH, SG));

  always_comb begin
    res_o = raw_i[OUT_WIDTH-1:0];
    sat_o = 1'b0;
    if (SG) begin
      if ($signed(raw_i) > $signed(MAXV)) begin
        res_o = MAXV[OUT_WIDTH-1:0];
        sat_o = 1'b1;
      end else if ($signed(raw_i) < $signed(MINV)) begin
        res_o = MINV[OUT_WIDTH-1:0];
        sat_o = 1'b1;
      end
    end else if (raw_i > MAXV) begin
      res_o = MAXV[OUT_WIDTH-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/saturating_accumulator.sv
// Saturating pass-through / accumulate stage with a
// single valid/ready output register.
module saturating_accumulator
  import saturating_accumulator_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 4,
  parameter int SIGNED    = 0
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 mode,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat,
  output logic                 sat_sticky
);

  localparam bit SG = (SIGNED != 0);
  localparam int RW =
    ((IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH) + 2;

  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_sat_q, out_sat_d;
  logic                 sticky_q, sticky_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;

  logic                 accept;
  logic [OUT_WIDTH-1:0] acc_base;
  logic [RW-1:0]        in_ext, acc_ext, raw;
  logic [OUT_WIDTH-1:0] clamp_res;
  logic                 clamp_sat;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // a same-cycle clear makes the beat see an empty accumulator
  assign acc_base = clear ? '0 : acc_q;
  assign in_ext   =
    {{(RW-IN_WIDTH){SG && in_data[IN_WIDTH-1]}}, in_data};
  assign acc_ext  =
    {{(RW-OUT_WIDTH){SG && acc_base[OUT_WIDTH-1]}}, acc_base};

  always_comb begin
    raw = in_ext;
    if (mode_e'(mode) == MODE_ACC) raw = acc_ext + in_ext;
  end

  sat_clamp #(
    .RAW_WIDTH (RW),
    .OUT_WIDTH (OUT_WIDTH),
    .SIGNED    (SIGNED)
  ) u_clamp (
    .raw_i (raw),
    .res_o (clamp_res),
    .sat_o (clamp_sat)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    sticky_d    = sticky_q;
    acc_d       = acc_q;
    if (clear) begin
      acc_d    = '0;
      sticky_d = 1'b0;
    end
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = clamp_res;
      out_sat_d   = clamp_sat;
      sticky_d    = sticky_d | clamp_sat;
      if (mode_e'(mode) == MODE_ACC) acc_d = clamp_res;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      sticky_q    <= 1'b0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sticky_q    <= sticky_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sat    = out_sat_q;
  assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_saturating_accumulator.sv
// Bench for saturating_accumulator: unsigned and signed
// instances share stimulus and are checked against a model.
module tb_saturating_accumulator;

  localparam int IW = 8;
  localparam int OW = 4;

  logic clk = 1'b0;
  logic rst_b, mode, clear, in_valid, out_ready;
  logic [IW-1:0] in_data;

  logic in_ready, out_valid, out_sat, sat_sticky;
  logic [OW-1:0] out_data;
  logic s_in_ready, s_out_valid, s_out_sat, s_sat_sticky;
  logic [OW-1:0] s_out_data;

  int n_chk = 0;
  int n_pass = 0;

  // model state: index 0 = unsigned, 1 = signed
  bit m_valid;
  int m_data[2];
  bit m_sat[2];
  int m_acc[2];
  bit m_sticky[2];

  always #5 clk = ~clk;

  saturating_accumulator #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .SIGNED(0)
  ) u_dut (
    .clk(clk), .rst_b(rst_b), .mode(mode), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .sat_sticky(sat_sticky)
  );

  saturating_accumulator #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .SIGNED(1)
  ) u_sdut (
    .clk(clk), .rst_b(rst_b), .mode(mode), .clear(clear),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_data(s_out_data),
    .out_sat(s_out_sat), .sat_sticky(s_sat_sticky)
  );

  function automatic int clampv(input int raw, input bit s,
                                output bit sat);
    int hi, lo;
    hi = s ? (1 << (OW - 1)) - 1 : (1 << OW) - 1;
    lo = s ? -(1 << (OW - 1)) : 0;
    sat = (raw > hi) || (raw < lo);
    if (raw > hi) return hi;
    if (raw < lo) return lo;
    return raw;
  endfunction

  task automatic model_step();
    bit take, s;
    int x, base, c;
    if (!rst_b) begin
      m_valid = 0;
      for (int k = 0; k < 2; k++) begin
        m_data[k] = 0; m_sat[k] = 0;
        m_acc[k] = 0; m_sticky[k] = 0;
      end
      return;
    end
    take = in_valid && (!m_valid || out_ready);
    for (int k = 0; k < 2; k++) begin
      if (clear) begin
        m_acc[k] = 0; m_sticky[k] = 0;
      end
      if (take) begin
        x = (k == 1) ? int'(signed'(in_data)) : int'(in_data);
        base = m_acc[k];
        c = clampv(mode ? base + x : x, k == 1, s);
        m_data[k] = c;
        m_sat[k] = s;
        if (mode) m_acc[k] = c;
        m_sticky[k] = m_sticky[k] | s;
      end
    end
    if (take) m_valid = 1;
    else if (out_ready) m_valid = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [IW-1:0] d);
    in_valid = 1; in_data = d;
    tick();
    in_valid = 0;
  endtask

  task automatic pulse_clear();
    clear = 1; in_valid = 0;
    tick();
    clear = 0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst_b = 0; mode = 0; clear = 0; in_valid = 0;
    in_data = '0; out_ready = 0;
    tick(); tick();
    got = {out_valid, out_sat, sat_sticky, out_data,
           s_out_valid};
    n_chk++;
    if (got !== 8'h0)
      $display("FAIL reset_state got %h want 00", got);
    else n_pass++;
    #1;
    n_chk++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_ready got %b want 1", in_ready);
    else n_pass++;
    rst_b = 1;
    tick();
  endtask

  task automatic test_pass_mode();
    logic [7:0] din [5] = '{8'd0, 8'd1, 8'd15, 8'd32, 8'd128};
    logic [3:0] dexp [5] = '{4'd0, 4'd1, 4'd15, 4'd15, 4'd15};
    bit sexp [5] = '{0, 0, 0, 1, 1};
    mode = 0; out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      beat(din[i]);
      n_chk++;
      if ({out_valid, out_data, out_sat, sat_sticky} !==
          {1'b1, dexp[i], sexp[i], sexp[i]})
        $display("FAIL pass[%0d] got v%b d%h s%b k%b want d%h s%b",
                 i, out_valid, out_data, out_sat, sat_sticky,
                 dexp[i], sexp[i]);
      else n_pass++;
    end
    pulse_clear();
    n_chk++;
    if (sat_sticky !== 1'b0)
      $display("FAIL clear_sticky got %b want 0", sat_sticky);
    else n_pass++;
  endtask

  task automatic test_accumulate();
    logic [7:0] din [6] = '{8'd7, 8'd7, 8'd7, 8'd8, 8'd7, 8'd1};
    logic [3:0] dexp [6] = '{4'd7, 4'd14, 4'd15, 4'd8, 4'd15, 4'd15};
    bit sexp [6] = '{0, 0, 1, 0, 0, 1};
    mode = 1; out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) pulse_clear();
      beat(din[i]);
      n_chk++;
      if ({out_data, out_sat} !== {dexp[i], sexp[i]})
        $display("FAIL acc[%0d] got d%h s%b want d%h s%b",
                 i, out_data, out_sat, dexp[i], sexp[i]);
      else n_pass++;
    end
    pulse_clear();
    beat(8'd3);
    n_chk++;
    if ({out_data, out_sat, sat_sticky} !== {4'd3, 1'b0, 1'b0})
      $display("FAIL acc_after_clear got d%h s%b k%b want d3 s0 k0",
               out_data, out_sat, sat_sticky);
    else n_pass++;
  endtask

  task automatic test_signed();
    logic [7:0] din [4] = '{8'h80, 8'h05, 8'hF9, 8'h07};
    logic [3:0] dexp [4] = '{4'h8, 4'h5, 4'h9, 4'h7};
    bit sexp [4] = '{1, 0, 0, 0};
    pulse_clear();
    mode = 0; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      beat(din[i]);
      n_chk++;
      if ({s_out_data, s_out_sat} !== {dexp[i], sexp[i]})
        $display("FAIL signed[%0d] got d%h s%b want d%h s%b",
                 i, s_out_data, s_out_sat, dexp[i], sexp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    mode = 0; out_ready = 1;
    beat(8'd5);
    out_ready = 0; in_valid = 1; in_data = 8'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if ({in_ready, out_valid, out_data} !== {2'b01, 4'd5})
        $display("FAIL bp_hold[%0d] got r%b v%b d%h want r0 v1 d5",
                 i, in_ready, out_valid, out_data);
      else n_pass++;
      tick();
    end
    out_ready = 1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1)
      $display("FAIL bp_release_ready got %b want 1", in_ready);
    else n_pass++;
    tick();
    in_valid = 0;
    n_chk++;
    if ({out_valid, out_data} !== {1'b1, 4'd9})
      $display("FAIL bp_next got v%b d%h want v1 d9",
               out_valid, out_data);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    pulse_clear();
    mode = 1; out_ready = 1;
    beat(8'd12);
    out_ready = 0; in_valid = 1; in_data = 8'd1;
    rst_b = 0;
    tick();
    rst_b = 1; in_valid = 0;
    n_chk++;
    if ({out_valid, sat_sticky} !== 2'b00)
      $display("FAIL rst_mid got v%b k%b want v0 k0",
               out_valid, sat_sticky);
    else n_pass++;
    out_ready = 1;
    beat(8'd2);
    n_chk++;
    if ({out_valid, out_data} !== {1'b1, 4'd2})
      $display("FAIL rst_mid_next got v%b d%h want v1 d2",
               out_valid, out_data);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] e0, e1;
    for (int i = 0; i < 400; i++) begin
      rst_b = ($urandom_range(0, 49) != 0);
      mode = $urandom_range(0, 1);
      clear = ($urandom_range(0, 9) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      in_data = ($urandom_range(0, 1) != 0) ?
                8'($urandom_range(0, 6)) :
                8'($urandom);
      #1;
      n_chk++;
      if (in_ready !== (!m_valid || out_ready))
        $display("FAIL rnd_ready[%0d] got %b want %b",
                 i, in_ready, !m_valid || out_ready);
      else n_pass++;
      tick();
      e0 = m_data[0][3:0];
      e1 = m_data[1][3:0];
      n_chk++;
      if (out_valid !== m_valid || s_out_valid !== m_valid ||
          sat_sticky !== m_sticky[0] ||
          s_sat_sticky !== m_sticky[1] ||
          (m_valid && ({out_data, out_sat} !== {e0, m_sat[0]} ||
                       {s_out_data, s_out_sat} !== {e1, m_sat[1]})))
        $display("FAIL rnd[%0d] got v%b%b d%h/%h s%b%b k%b%b want v%b d%h/%h s%b%b k%b%b",
                 i, out_valid, s_out_valid, out_data, s_out_data,
                 out_sat, s_out_sat, sat_sticky, s_sat_sticky,
                 m_valid, e0, e1, m_sat[0], m_sat[1],
                 m_sticky[0], m_sticky[1]);
      else n_pass++;
    end
    rst_b = 1; clear = 0; in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_pass_mode();
    test_accumulate();
    test_signed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
